// File: rtl/ser_loader_if.sv
// Bus bundle for ser_loader: frame control and serial input toward the block,
// received word, status and frame count back to the downstream logic.
`timescale 1ns/1ps
interface ser_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             sdi;
  logic             sdi_valid;
  logic [WIDTH-1:0] data_out;
  logic             load;
  logic             busy;
  logic             parity_err;
  logic [7:0]       frame_cnt;

  modport master (
    output start, abort, sdi, sdi_valid,
    input  data_out, load, busy, parity_err, frame_cnt
  );

  modport slave (
    input  start, abort, sdi, sdi_valid,
    output data_out, load, busy, parity_err, frame_cnt
  );
endinterface

// File: rtl/ser_loader.sv
// Serial-to-parallel frame loader: shifts in WIDTH bits LSB first, checks an
// optional even-parity bit, and strobes load together with the new data_out.
`timescale 1ns/1ps
module ser_loader #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input logic        clk,
  input logic        reset,
  ser_loader_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data_out;
  logic             r_load;
  logic             r_parity_err;
  logic [7:0]       r_frame_cnt;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_last_bit;

  always_comb begin
    w_shift_next            = r_shift;
    w_shift_next[r_bit_cnt] = bus.sdi;
    w_last_bit              = (r_bit_cnt == CW'(WIDTH - 1));
  end

  // Delivery happens on the edge that accepts the final bit, so load and
  // data_out appear together during the single DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_load       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_load <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_state      <= SHIFT;
              r_bit_cnt    <= '0;
              r_shift      <= '0;
              r_parity_err <= 1'b0;
            end
          end
          SHIFT: begin
            if (bus.sdi_valid) begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                if (PARITY_EN) begin
                  r_state <= PARITY;
                end else begin
                  r_state     <= DONE;
                  r_data_out  <= w_shift_next;
                  r_frame_cnt <= r_frame_cnt + 8'd1;
                  r_load      <= 1'b1;
                end
              end
            end
          end
          PARITY: begin
            if (bus.sdi_valid) begin
              r_state <= DONE;
              if (bus.sdi != ^r_shift) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data_out  <= r_shift;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_load      <= 1'b1;
              end
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.load       = r_load;
  assign bus.busy       = (r_state != IDLE);
  assign bus.parity_err = r_parity_err;
  assign bus.frame_cnt  = r_frame_cnt;
endmodule

// File: doc/ser_loader.md
SER_LOADER -- requirements
Module: ser_loader

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits; legal range 2..32.
REQ-002 Parameter PARITY_EN, default 1; 1 = one even-parity bit follows the payload, 0 = no parity bit.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a new frame; sampled only in IDLE.
REQ-006 abort  input  1  synchronous frame cancel; highest priority after reset.
REQ-007 sdi  input  1  serial data bit, LSB first.
REQ-008 sdi_valid  input  1  sdi qualifier; one bit accepted per cycle with sdi_valid=1.
REQ-009 data_out  output  WIDTH  last successfully received word; drives downstream register data.
REQ-010 load  output  1  one-cycle strobe; drives downstream register en.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 parity_err  output  1  sticky flag for a failed parity check on the most recent frame.
REQ-013 frame_cnt  output  8  count of good frames delivered; wraps 255 -> 0.

Function
REQ-014 The FSM SHALL have four states: IDLE, SHIFT, PARITY, DONE.
REQ-015 IDLE with start=1 SHALL go to SHIFT, clear the bit counter and shift register, and clear parity_err.
REQ-016 start outside IDLE SHALL be ignored with no effect on state or data.
REQ-017 In SHIFT, each cycle with sdi_valid=1 SHALL accept sdi into bit position = bit counter (LSB first) and increment the counter.
REQ-018 Cycles with sdi_valid=0 SHALL hold all state; gaps of any length are legal.
REQ-019 Acceptance of bit WIDTH-1 SHALL move the FSM to PARITY if PARITY_EN=1, else to DONE.
REQ-020 In PARITY, the first cycle with sdi_valid=1 SHALL compare sdi with the XOR of the payload bits (even parity), set parity_err on mismatch, and go to DONE.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 On entry to DONE with parity_err=0, the block SHALL update data_out to the payload, increment frame_cnt, and pulse load high for that same DONE cycle.
REQ-023 On entry to DONE with parity_err=1, data_out and frame_cnt SHALL be unchanged and load SHALL remain 0.
REQ-024 Latency: load and the new data_out SHALL be visible in the cycle after the clock edge that accepts the final bit (parity bit, or bit WIDTH-1 when PARITY_EN=0).
REQ-025 load SHALL never be high for two consecutive cycles.
REQ-026 load and data_out SHALL change together, so a downstream register with en=load captures the new word on the next edge.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, discard the partial word, and produce no load; data_out, frame_cnt, and parity_err SHALL be kept.
REQ-028 abort and start both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 sdi_valid is ignored in IDLE and DONE, so no bit is accepted there.
REQ-030 parity_err SHALL hold its value until the next accepted start or reset.

Reset
REQ-031 reset=0 SHALL immediately force IDLE and zero the bit counter, shift register, data_out, frame_cnt, and parity_err, and force load=0 and busy=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; no load SHALL occur when reset is released.
REQ-033 After reset is released, the first possible frame start SHALL be the first rising edge with start=1.

Verification
REQ-034 WIDTH=8, PARITY_EN=1: start, then bits 1,0,1,0,0,1,0,1 and parity 0 on consecutive cycles -> one load pulse, data_out=0xA5, frame_cnt=1, parity_err=0.
REQ-035 Same payload with parity bit 1 -> no load, data_out keeps its prior value, parity_err=1 until the next start.
REQ-036 Payload 0x3C with random 0-5 cycle sdi_valid gaps, plus start pulses injected mid-frame -> single load, data_out=0x3C, start pulses ignored.
REQ-037 abort after the 4th bit, then a full frame 0xFF with parity 0 -> exactly one load, data_out=0xFF.
REQ-038 reset pulsed low after the 5th bit -> all outputs 0 immediately, no load after release, and the next full frame 0x01 with parity 1 is received correctly.
REQ-039 256 good frames -> frame_cnt wraps to 0, with load asserted exactly 256 times.
